// File: rtl/test_block_pkg.sv
// rtl/test_block_pkg.sv - shared width and operation encoding for the nibble-transform unit
package test_block_pkg;

  localparam int W = 4;

  typedef enum logic [2:0] {
    PASS   = 3'd0,
    INV    = 3'd1,
    REV    = 3'd2,
    ROTL   = 3'd3,
    GRAY   = 3'd4,
    POPCNT = 3'd5,
    ACC    = 3'd6,
    DIFF   = 3'd7
  } op_e;

endpackage

// File: rtl/test_block_if.sv
// rtl/test_block_if.sv - operand/result bundle for the nibble-transform unit
interface test_block_if;
  import test_block_pkg::*;

  logic [W-1:0] a;
  logic [2:0]   op;
  logic         in_valid;
  logic [W-1:0] b;
  logic         out_valid;

  modport master (output a, output op, output in_valid, input b, input out_valid);
  modport slave  (input a, input op, input in_valid, output b, output out_valid);

endinterface

// File: rtl/test_block_alu.sv
// rtl/test_block_alu.sv - combinational next-result logic; ACC saturates when TEST_BLOCK_SAT_EN is defined
module test_block_alu
  import test_block_pkg::*;
(
  input  op_e          op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b_cur,
  input  logic [W-1:0] a_prev,
  output logic [W-1:0] next_b
);

  logic [W-1:0] ones;
  logic [W-1:0] rev;
`ifdef TEST_BLOCK_SAT_EN
  logic [W:0]   sum;
`else
  logic [W-1:0] sum;
`endif

  always_comb begin
    ones = '0;
    rev  = '0;
    for (int i = 0; i < W; i++) begin
      ones   = ones + {{(W-1){1'b0}}, a[i]};
      rev[i] = a[W-1-i];
    end
`ifdef TEST_BLOCK_SAT_EN
    sum = {1'b0, b_cur} + {1'b0, a};
`else
    sum = b_cur + a;
`endif
  end

  always_comb begin
    next_b = a;
    unique case (op)
      PASS:   next_b = a;
      INV:    next_b = ~a;
      REV:    next_b = rev;
      ROTL:   next_b = {a[W-2:0], a[W-1]};
      GRAY:   next_b = a ^ (a >> 1);
      POPCNT: next_b = ones;
`ifdef TEST_BLOCK_SAT_EN
      ACC:    next_b = sum[W] ? '1 : sum[W-1:0];
`else
      ACC:    next_b = sum;
`endif
      DIFF:   next_b = a ^ a_prev;
      default: next_b = a;
    endcase
  end

endmodule

// File: rtl/test_block.sv
// rtl/test_block.sv - registered 4-bit nibble-transform unit, 1-cycle latency; TEST_BLOCK_SAT_EN selects saturating ACC
module test_block
  import test_block_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  test_block_if.slave bus
);

  logic [W-1:0] b_q;
  logic [W-1:0] a_prev;
  logic         valid_q;
  logic [W-1:0] next_b;

  test_block_alu u_alu (
    .op     (op_e'(bus.op)),
    .a      (bus.a),
    .b_cur  (b_q),
    .a_prev (a_prev),
    .next_b (next_b)
  );

  // a_prev follows every accepted input so DIFF is independent of which op ran last
  always_ff @(posedge clk) begin
    if (rst) begin
      b_q     <= '0;
      a_prev  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        b_q    <= next_b;
        a_prev <= bus.a;
      end
    end
  end

  assign bus.b         = b_q;
  assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_test_block.sv
// tb/tb_test_block.sv - vector table plus randomized model check for test_block
module tb_test_block;
  import test_block_pkg::*;

  typedef struct {
    string      name;
    logic       rst;
    logic       v;
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] exp_b;
    logic       exp_v;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  test_block_if bus ();

  test_block dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  function automatic vec_t mk(string n, logic r, logic v, logic [2:0] op,
                              logic [3:0] a, logic [3:0] eb, logic ev);
    vec_t t;
    t.name = n; t.rst = r; t.v = v; t.op = op; t.a = a; t.exp_b = eb; t.exp_v = ev;
    return t;
  endfunction

  // Reference computed from the operation definitions with plain integer arithmetic
  function automatic logic [3:0] model(int op, int a, int b, int prev);
    int r;
    r = 0;
    case (op)
      0: r = a;
      1: r = 15 - a;
      2: for (int i = 0; i < 4; i++) if (((a >> i) & 1) != 0) r += (8 >> i);
      3: r = (a * 2) % 16 + a / 8;
      4: r = a ^ (a / 2);
      5: for (int i = 0; i < 4; i++) r += (a >> i) & 1;
`ifdef TEST_BLOCK_SAT_EN
      6: r = (a + b > 15) ? 15 : a + b;
`else
      6: r = (a + b) % 16;
`endif
      default: r = a ^ prev;
    endcase
    return r[3:0];
  endfunction

  task automatic apply(logic r, logic v, logic [2:0] op, logic [3:0] a);
    rst          = r;
    bus.in_valid = v;
    bus.op       = op;
    bus.a        = a;
    @(posedge clk);
    #1;
  endtask

  task automatic check(string n, logic [3:0] eb, logic ev);
    checks++;
    if (bus.b !== eb || bus.out_valid !== ev) begin
      errors++;
      $display("FAIL %s: got b=%b out_valid=%b, want b=%b out_valid=%b",
               n, bus.b, bus.out_valid, eb, ev);
    end
  endtask

  initial begin
    logic [3:0] mb, mp, ra;
    logic       mv, rr, rv;
    logic [2:0] rop;
`ifdef TEST_BLOCK_SAT_EN
    logic [3:0] acc2 = 4'b1111;
`else
    logic [3:0] acc2 = 4'b0110;
`endif

    vecs.push_back(mk("reset0",    1, 1, 3'd0, 4'b1111, 4'b0000, 0));
    vecs.push_back(mk("reset1",    1, 1, 3'd0, 4'b1111, 4'b0000, 0));
    vecs.push_back(mk("pass",      0, 1, 3'd0, 4'b1010, 4'b1010, 1));
    vecs.push_back(mk("inv",       0, 1, 3'd1, 4'b1010, 4'b0101, 1));
    vecs.push_back(mk("gray",      0, 1, 3'd4, 4'b1010, 4'b1111, 1));
    vecs.push_back(mk("popcnt",    0, 1, 3'd5, 4'b1010, 4'b0010, 1));
    vecs.push_back(mk("rev",       0, 1, 3'd2, 4'b1100, 4'b0011, 1));
    vecs.push_back(mk("rotl",      0, 1, 3'd3, 4'b1100, 4'b1001, 1));
    vecs.push_back(mk("popcnt_f",  0, 1, 3'd5, 4'b1111, 4'b0100, 1));
    vecs.push_back(mk("acc_rst",   1, 0, 3'd0, 4'b0000, 4'b0000, 0));
    vecs.push_back(mk("acc1",      0, 1, 3'd6, 4'b1010, 4'b1010, 1));
    vecs.push_back(mk("acc2",      0, 1, 3'd6, 4'b1100, acc2,    1));
    vecs.push_back(mk("diff_rst",  1, 0, 3'd0, 4'b0000, 4'b0000, 0));
    vecs.push_back(mk("diff1",     0, 1, 3'd7, 4'b1010, 4'b1010, 1));
    vecs.push_back(mk("diff2",     0, 1, 3'd7, 4'b1100, 4'b0110, 1));
    vecs.push_back(mk("diff3",     0, 1, 3'd7, 4'b0000, 4'b1100, 1));
    vecs.push_back(mk("stall1",    0, 0, 3'd7, 4'b0101, 4'b1100, 0));
    vecs.push_back(mk("stall2",    0, 0, 3'd1, 4'b1001, 4'b1100, 0));
    vecs.push_back(mk("stall3",    0, 0, 3'd6, 4'b0011, 4'b1100, 0));
    vecs.push_back(mk("diff_post", 0, 1, 3'd7, 4'b0110, 4'b0110, 1));
    vecs.push_back(mk("mid_rst0",  1, 0, 3'd0, 4'b0000, 4'b0000, 0));
    vecs.push_back(mk("mid_acc1",  0, 1, 3'd6, 4'b0110, 4'b0110, 1));
    vecs.push_back(mk("mid_rst1",  1, 1, 3'd6, 4'b0101, 4'b0000, 0));
    vecs.push_back(mk("mid_acc2",  0, 1, 3'd6, 4'b0011, 4'b0011, 1));
    vecs.push_back(mk("acc_chain", 0, 1, 3'd6, 4'b0100, 4'b0111, 1));

    foreach (vecs[i]) begin
      apply(vecs[i].rst, vecs[i].v, vecs[i].op, vecs[i].a);
      check(vecs[i].name, vecs[i].exp_b, vecs[i].exp_v);
    end

    // Randomized stream; rst and stalls are sprinkled in to exercise holds and mid-stream resets
    apply(1, 0, 3'd0, 4'd0);
    mb = 0; mp = 0; mv = 0;
    for (int n = 0; n < 400; n++) begin
      rr  = ($urandom_range(0, 19) == 0);
      rv  = ($urandom_range(0, 3) != 0);
      rop = 3'($urandom_range(0, 7));
      ra  = 4'($urandom_range(0, 15));
      apply(rr, rv, rop, ra);
      if (rr) begin
        mb = 0; mp = 0; mv = 0;
      end else if (rv) begin
        mb = model(int'(rop), int'(ra), int'(mb), int'(mp));
        mp = ra;
        mv = 1;
      end else begin
        mv = 0;
      end
      check($sformatf("rand%0d_op%0d", n, rop), mb, mv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/test_block.md
Name: test_block

Overview:
- 4-bit registered nibble-transform unit. Applies one of eight operations to input nibble `a` and presents the result on `b` one clock later.
- Used as a small datapath leaf and as the reference DUT for waveform-based bring-up benches.
- Two operations are stateful: a running accumulator and a change detector.

Parameters:
- W, 4, datapath width in bits. Only 4 is required to be supported; all widths below assume W=4.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- a  input  4  operand nibble
- op  input  3  operation select, sampled together with `a`
- in_valid  input  1  qualifies `a`/`op` in the current cycle
- b  output  4  registered result
- out_valid  output  1  high for one cycle when `b` carries a new result

Behaviour:
- Interface: one clock, `clk`. Reset `rst` is synchronous and active-high; it is sampled only on the `clk` rising edge.
- Reset values: b=0000, out_valid=0, internal a_prev=0000.
- Reset has priority over in_valid in the same edge; a reset mid-stream discards any pending result.
- Latency: exactly 1 cycle. On an edge with in_valid=1, b is loaded with f(op, a) and out_valid=1.
- On an edge with in_valid=0: b holds its value, a_prev holds, out_valid=0.
- Back-to-back in_valid=1 cycles are accepted every cycle; there is no backpressure.
- op encoding:
  - 0 PASS: b=a
  - 1 INV: b=~a
  - 2 REV: b={a[0],a[1],a[2],a[3]}
  - 3 ROTL: b={a[2:0],a[3]}
  - 4 GRAY: b=a^(a>>1)
  - 5 POPCNT: b=number of ones in a (0..4), zero-extended
  - 6 ACC: b=(b+a) mod 16, where b is the current registered output; wraps past 15
  - 7 DIFF: b=a^a_prev (bits that changed since the last accepted input)
- a_prev is updated to `a` on every accepted input, regardless of op, so DIFF always compares against the previous accepted `a`.
- ACC uses the current `b` even if the previous result came from another op.
- All arithmetic is unsigned, 4-bit, and carry-discarded.

Optional Feature:
- Macro: TEST_BLOCK_SAT_EN.
- Defined: ACC saturates, b=min(b+a, 15).
- Undefined: ACC wraps modulo 16.
- All other ops are identical with or without the macro.

Decomposition:
- Package test_block_pkg holds:
  - typedef op_e (3-bit enum PASS, INV, REV, ROTL, GRAY, POPCNT, ACC, DIFF)
  - constant W=4
- One natural sub-module: test_block_alu. It is purely combinational, taking (op, a, b_cur, a_prev) and producing next_b.
- The top level holds the b, a_prev and out_valid registers and the reset logic.

Test Plan:
- Reset: assert rst for 2 cycles with in_valid=1, a=1111 -> b=0000, out_valid=0. Release -> the first result appears on the next edge.
- Stateless ops, a=1010:
  - PASS -> 1010
  - INV -> 0101
  - GRAY -> 1111
  - POPCNT -> 0010
  With a=1100: REV -> 0011, ROTL -> 1001. Each result arrives 1 cycle later with out_valid=1.
- ACC wrap: after reset, op=6 with a=1010 then 1100 -> b=1010 then 0110. With TEST_BLOCK_SAT_EN defined -> 1010 then 1111.
- DIFF: op=7 with a=1010, 1100, 0000 -> b=1010, 0110, 1100.
- Stall: in_valid=0 for 3 cycles while a changes -> b is held and out_valid=0. A following DIFF still compares against the last accepted `a`.
- Reset mid-ACC: accumulate to 0110, pulse rst for 1 cycle, then ACC with a=0011 -> b=0011.
